// File: rtl/score_digit_scheduler_pkg.sv
// Shared types for the score digit scheduler: converter states, BCD digit type, clamp helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package score_digit_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Largest value representable in n decimal digits.
    function automatic int unsigned pow10_minus1(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/score_digit_scheduler_if.sv
// Score load, beam position and sprite-facing outputs of the score digit scheduler.
// Latency: n/a (signal bundle).
// Backpressure: none; busy_out is advisory only.
interface score_digit_scheduler_if
    import score_digit_scheduler_pkg::*;
#(
    parameter int SCORE_WIDTH = 14
);
    logic [SCORE_WIDTH-1:0] score_in;
    logic                   score_valid_in;
    logic [10:0]            x_in;
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;
    bcd_digit_t             number_out;
    logic [10:0]            digit_x_out;
    logic [10:0]            hcount_out;
    logic [9:0]             vcount_out;
    logic                   blank_out;
    logic                   busy_out;

    modport master (
        output score_in, score_valid_in, x_in, hcount_in, vcount_in,
        input  number_out, digit_x_out, hcount_out, vcount_out, blank_out, busy_out
    );

    modport slave (
        input  score_in, score_valid_in, x_in, hcount_in, vcount_in,
        output number_out, digit_x_out, hcount_out, vcount_out, blank_out, busy_out
    );

endinterface

// File: rtl/score_digit_scheduler_bcd_double_dabble.sv
// Sequential double-dabble binary-to-BCD converter (bcd_double_dabble) with start/done handshake.
// Latency: 1 load cycle + BIN_WIDTH shift cycles, done_o pulses in the following cycle.
// Backpressure: start_i is accepted (start_ack_o) only while idle; it is ignored mid-conversion.
module score_digit_scheduler_bcd_double_dabble
    import score_digit_scheduler_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic [BIN_WIDTH-1:0]        bin_i,
    output logic                        start_ack_o,
    output logic                        done_o,
    output logic                        busy_o,
    output bcd_digit_t [NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    conv_state_t          state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        start_ack_o = 1'b0;
        done_o      = 1'b0;
        adj         = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_ack_o = 1'b1;
                    bin_d       = bin_i;
                    bcd_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/score_digit_scheduler.sv
// Time-shares one glyph sprite across NUM_DIGITS score cells; SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: load to ready SCORE_WIDTH+2 cycles, display at next commit line; cell outputs lag hcount by 1.
// Backpressure: none; a strobe while busy overwrites the pending score, only the latest is converted.
module score_digit_scheduler
    import score_digit_scheduler_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCORE_WIDTH = 14,
    parameter int DIGIT_WIDTH = 24,
    parameter int DIGIT_GAP   = 4,
    parameter int COMMIT_LINE = 720
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    score_digit_scheduler_if.slave bus
);
    localparam int                PITCH     = DIGIT_WIDTH + DIGIT_GAP;
    localparam int                COL_W     = $clog2(PITCH);
    localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned       MAX_SCORE = pow10_minus1(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [SCORE_WIDTH-1:0]      pend_q, pend_d, score_clamped;
    logic                        pend_vld_q, pend_vld_d;
    bcd_digit_t [NUM_DIGITS-1:0] rdy_q, rdy_d, disp_q, disp_d, conv_bcd;
    logic                        rdy_vld_q, rdy_vld_d;
    logic                        conv_ack, conv_done, conv_busy, commit_now, lead_blank;
    logic [COL_W-1:0]            col_q, col_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        act_q, act_d;
    bcd_digit_t                  number_q, number_d;
    logic [10:0]                 digit_x_q, digit_x_d, hcount_q;
    logic [9:0]                  vcount_q;
    logic                        blank_q, blank_d;

    assign score_clamped = (32'(bus.score_in) > MAX_SCORE) ? SCORE_WIDTH'(MAX_SCORE) : bus.score_in;

    // A strobe in the same cycle the converter consumes the old value keeps the new one pending.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (conv_ack) begin
            pend_vld_d = 1'b0;
        end
        if (bus.score_valid_in) begin
            pend_d     = score_clamped;
            pend_vld_d = 1'b1;
        end
    end

    score_digit_scheduler_bcd_double_dabble #(
        .BIN_WIDTH  (SCORE_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) bcd_double_dabble (
        .clk_i       (pixel_clk_in),
        .rst_n_i     (rst_in),
        .start_i     (pend_vld_q),
        .bin_i       (pend_q),
        .start_ack_o (conv_ack),
        .done_o      (conv_done),
        .busy_o      (conv_busy),
        .bcd_o       (conv_bcd)
    );

    assign commit_now = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'(COMMIT_LINE)) && rdy_vld_q;

    // A fresh result outranks the commit; it waits for the next frame's commit line.
    always_comb begin
        rdy_d     = rdy_q;
        rdy_vld_d = rdy_vld_q;
        disp_d    = disp_q;
        if (conv_done) begin
            rdy_d     = conv_bcd;
            rdy_vld_d = 1'b1;
        end else if (commit_now) begin
            disp_d    = rdy_q;
            rdy_vld_d = 1'b0;
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        lz    = '0;
        lz[0] = (disp_q[LAST_IDX] == 4'd0);
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz[i] = lz[i-1] & (disp_q[NUM_DIGITS-1-i] == 4'd0);
        end
        lead_blank = lz[idx_d] & (idx_d != LAST_IDX);
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Outputs are loaded from the next-state index so they line up with hcount_out.
    always_comb begin
        col_d     = col_q;
        idx_d     = idx_q;
        act_d     = act_q;
        number_d  = number_q;
        digit_x_d = digit_x_q;
        blank_d   = blank_q;
        if (bus.hcount_in == bus.x_in) begin
            col_d = '0;
            idx_d = '0;
            act_d = 1'b1;
        end else if (act_q) begin
            if (col_q == COL_W'(PITCH - 1)) begin
                col_d = '0;
                if (idx_q == LAST_IDX) begin
                    act_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (act_d) begin
            number_d  = disp_q[LAST_IDX - idx_d];
            digit_x_d = bus.x_in + 11'(idx_d) * 11'(PITCH);
            blank_d   = lead_blank;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            rdy_q      <= '0;
            rdy_vld_q  <= 1'b0;
            disp_q     <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            act_q      <= 1'b0;
            number_q   <= '0;
            digit_x_q  <= '0;
            blank_q    <= 1'b0;
            hcount_q   <= '0;
            vcount_q   <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            rdy_q      <= rdy_d;
            rdy_vld_q  <= rdy_vld_d;
            disp_q     <= disp_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            number_q   <= number_d;
            digit_x_q  <= digit_x_d;
            blank_q    <= blank_d;
            hcount_q   <= bus.hcount_in;
            vcount_q   <= bus.vcount_in;
        end
    end

    assign bus.number_out  = number_q;
    assign bus.digit_x_out = digit_x_q;
    assign bus.hcount_out  = hcount_q;
    assign bus.vcount_out  = vcount_q;
    assign bus.blank_out   = blank_q;
    assign bus.busy_out    = conv_busy | pend_vld_q;

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Directed bench for score_digit_scheduler: score table plus overwrite and mid-conversion reset sequences.
module tb_score_digit_scheduler;
    import score_digit_scheduler_pkg::*;

    localparam int X0    = 100;
    localparam int PITCH = 28;

    typedef struct {
        logic [13:0] score;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    score_digit_scheduler_if #(.SCORE_WIDTH(14)) bus ();

    score_digit_scheduler #(
        .NUM_DIGITS  (4),
        .SCORE_WIDTH (14),
        .DIGIT_WIDTH (24),
        .DIGIT_GAP   (4),
        .COMMIT_LINE (720)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_n),
        .bus          (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [13:0] s);
        bus.score_in       = s;
        bus.score_valid_in = 1'b1;
        step();
        bus.score_valid_in = 1'b0;
    endtask

    task automatic commit();
        bus.hcount_in = 11'd0;
        bus.vcount_in = 10'd720;
        step();
        bus.hcount_in = 11'd2000;
        bus.vcount_in = 10'd0;
    endtask

    task automatic wait_busy(input string name, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (bus.busy_out && cnt < 200) begin
            cnt++;
            step();
        end
        check(name, cnt, exp_cycles);
    endtask

    // Sweeps one line across all cells and checks each cell at its first pixel.
    task automatic scan(input string tag, input logic [15:0] bcd, input logic [3:0] blank);
        logic exp_blank;
        bus.vcount_in = 10'd10;
        for (int h = 0; h <= X0 + 4*PITCH + 2; h++) begin
            bus.hcount_in = 11'(h);
            step();
            for (int k = 0; k < 4; k++) begin
                if (h == X0 + k*PITCH) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
                    exp_blank = blank[k];
`else
                    exp_blank = 1'b0;
`endif
                    check($sformatf("%s_num%0d", tag, k), 32'(bus.number_out), 32'(bcd[4*(3-k) +: 4]));
                    check($sformatf("%s_x%0d", tag, k), 32'(bus.digit_x_out), 32'(X0 + k*PITCH));
                    check($sformatf("%s_blank%0d", tag, k), 32'(bus.blank_out), 32'(exp_blank));
                    if (k == 0) begin
                        check($sformatf("%s_hcnt", tag), 32'(bus.hcount_out), 32'(h));
                        check($sformatf("%s_vcnt", tag), 32'(bus.vcount_out), 32'd10);
                    end
                end
            end
        end
        check($sformatf("%s_hold_num", tag), 32'(bus.number_out), 32'(bcd[3:0]));
        check($sformatf("%s_hold_x", tag), 32'(bus.digit_x_out), 32'(X0 + 3*PITCH));
        bus.hcount_in = 11'd2000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev_bcd;
        logic [3:0]  prev_blank;

        vecs[0] = '{14'd1234,  16'h1234, 4'b0000};
        vecs[1] = '{14'd16383, 16'h9999, 4'b0000};
        vecs[2] = '{14'd7,     16'h0007, 4'b0111};
        vecs[3] = '{14'd0,     16'h0000, 4'b0111};
        vecs[4] = '{14'd905,   16'h0905, 4'b0001};
        vecs[5] = '{14'd10000, 16'h9999, 4'b0000};

        rst_n              = 1'b0;
        bus.score_in       = '0;
        bus.score_valid_in = 1'b0;
        bus.x_in           = 11'(X0);
        bus.hcount_in      = 11'd2000;
        bus.vcount_in      = 10'd0;
        repeat (3) step();

        check("rst_num",    32'(bus.number_out),  32'd0);
        check("rst_x",      32'(bus.digit_x_out), 32'd0);
        check("rst_hcnt",   32'(bus.hcount_out),  32'd0);
        check("rst_vcnt",   32'(bus.vcount_out),  32'd0);
        check("rst_blank",  32'(bus.blank_out),   32'd0);
        check("rst_busy",   32'(bus.busy_out),    32'd0);

        rst_n = 1'b1;
        step();
        scan("rst_frame", 16'h0000, 4'b0111);
        prev_bcd   = 16'h0000;
        prev_blank = 4'b0111;

        for (int i = 0; i < 6; i++) begin
            bus.vcount_in = 10'd100;
            strobe(vecs[i].score);
            wait_busy($sformatf("v%0d_busy", i), 16);
            scan($sformatf("v%0d_old", i), prev_bcd, prev_blank);
            commit();
            scan($sformatf("v%0d_new", i), vecs[i].bcd, vecs[i].blank);
            prev_bcd   = vecs[i].bcd;
            prev_blank = vecs[i].blank;
        end

        // Overwrite: the second strobe lands mid-shift and is converted afterwards.
        strobe(14'd57);
        step();
        step();
        strobe(14'd58);
        wait_busy("ovr_busy", 29);
        commit();
        scan("ovr", 16'h0058, 4'b0011);

        // Reset during SHIFT with a second value pending.
        strobe(14'd4321);
        repeat (5) step();
        strobe(14'd1111);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_num",  32'(bus.number_out),  32'd0);
        check("mid_rst_x",    32'(bus.digit_x_out), 32'd0);
        check("mid_rst_hcnt", 32'(bus.hcount_out),  32'd0);
        check("mid_rst_busy", 32'(bus.busy_out),    32'd0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("post_rst_busy", 32'(bus.busy_out), 32'd0);
        commit();
        scan("post_rst", 16'h0000, 4'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/score_digit_scheduler.md
# score_digit_scheduler

Time-shares the single 1-bit number glyph ROM sprite (24x24 glyphs, 10 images) across NUM_DIGITS on-screen digit positions so one sprite instance can render a multi-digit decimal score. Takes a binary score and converts it to BCD with a sequential double-dabble engine. Commits the new digits to the display only at a frame boundary, so a score is never drawn half-updated. On every pixel it presents the glyph index and x origin of the digit cell under the beam, plus a 1-cycle-delayed hcount/vcount, to the glyph sprite that follows it.

## Interface
- NUM_DIGITS, 4: digit cells drawn, most significant digit leftmost.
- SCORE_WIDTH, 14: binary score width.
- DIGIT_WIDTH, 24: glyph width in pixels; matches the sprite WIDTH.
- DIGIT_GAP, 4: blank pixels between cells. Pitch = DIGIT_WIDTH+DIGIT_GAP.
- COMMIT_LINE, 720: vcount at which pending digits are committed.
- pixel_clk_in, input, 1: sole clock, rising edge.
- rst_in, input, 1: asynchronous, active-low reset.
- score_in, input, SCORE_WIDTH: binary score, sampled when score_valid_in=1.
- score_valid_in, input, 1: single-cycle load strobe.
- x_in, input, 11: left edge of digit 0 (MSD).
- hcount_in, input, 11: beam x.
- vcount_in, input, 10: beam y.
- number_out, output, 4: glyph index 0..9 for the cell under the beam.
- digit_x_out, output, 11: x origin of that cell; drives the sprite's x_in.
- hcount_out, output, 11: hcount_in delayed 1 cycle; drives the sprite's hcount_in.
- vcount_out, output, 10: vcount_in delayed 1 cycle; drives the sprite's vcount_in.
- blank_out, output, 1: suppresses the cell; ANDed externally with the sprite draw_out.
- busy_out, output, 1: conversion in progress or a load is pending.

## Operation
- Capture
  - On score_valid_in, score_in is clamped to 10^NUM_DIGITS-1, then written into the pending register.
  - A strobe while busy overwrites the pending value. Only the latest value is converted.
- Converter FSM
  - IDLE: if pending is valid, load the shift register and BCD accumulator (zeros), then go to SHIFT.
  - SHIFT: runs SCORE_WIDTH cycles. Each cycle, add 3 to every BCD nibble that is ≥5, then shift left 1 (all combinational within the cycle). After the last shift, go to DONE.
  - DONE: write the BCD result to the ready register, set ready_valid, return to IDLE.
  - A strobe arriving during SHIFT does not restart the conversion. It is converted afterwards.
- Commit
  - When hcount_in==0, vcount_in==COMMIT_LINE and ready_valid=1, copy ready into the display digits and clear ready_valid.
  - If DONE and the commit occur in the same cycle, DONE wins and the commit happens next frame.
- Cell tracking
  - A column counter and a digit index are registered.
  - hcount_in==x_in: column=0, index=0, active=1.
  - Otherwise, while active, the column increments. At pitch-1 the column wraps to 0 and the index increments.
  - After the last cell wraps, active=0.
  - Each cycle, register the following:
    - number_out = display digit[index].
    - digit_x_out = x_in + index*pitch; the multiply is by a constant, no divider.
    - hcount_out and vcount_out from the 1-cycle delay.
  - Outside the active span, number_out and digit_x_out hold their last values.
- busy_out = (state≠IDLE) | pending_valid.

## Timing
- Reset values
  - All outputs 0.
  - Display digits show 0…0.
  - FSM in IDLE; pending_valid and ready_valid cleared.
  - Reset mid-conversion discards both the conversion and any pending value.
- Load to ready: SCORE_WIDTH+2 cycles (1 capture, 1 load, SCORE_WIDTH shifts). Display update follows at the next commit point.
- Cell-tracking outputs lag their hcount by exactly 1 cycle. number_out, digit_x_out and hcount_out are mutually aligned.
- The x_in+NUM_DIGITS*pitch ≤ 1280 bound is the integrator's responsibility and is not checked.

## Configuration
- SCORE_LEADING_ZERO_BLANK_EN defined:
  - blank_out=1 for any leading-zero cell left of the first nonzero digit.
  - The least significant cell is never blanked, so score 0 shows a single "0".
- SCORE_LEADING_ZERO_BLANK_EN undefined: blank_out is tied 0 and all NUM_DIGITS cells are drawn.
- blank_out is registered alongside number_out in both cases.

## Structure
- A shared package holds the following:
  - The converter state enum (IDLE, SHIFT, DONE).
  - The bcd_digit_t (4-bit) typedef.
  - A function returning 10^N-1 for the clamp constant.
- One sub-module, bcd_double_dabble: the sequential converter with start/done handshake. The cell tracker and commit logic stay in the top module.

## Test plan
- Reset, then frame → all cells number_out=0; digit_x_out values x_in, x_in+28, x_in+56, x_in+84 with x_in=100.
- score_in=1234 strobed at vcount 100 → busy_out high for 16 cycles. Display unchanged until vcount 720. Next frame cells read 1,2,3,4.
- score_in=16383 → clamped, displays 9,9,9,9.
- Two strobes (57 then 58) 3 cycles apart → only 58 committed (0,0,5,8). busy_out stays high until the second conversion completes.
- With SCORE_LEADING_ZERO_BLANK_EN, score 7 → blank_out=1 on cells 0–2 and 0 on cell 3. Score 0 → only cell 3 unblanked.
- Assert rst_in low during SHIFT → outputs 0 immediately. After release, the old display holds zeros and busy_out=0.
